// File: rtl/tap_clk_switch_ctrl_pkg.sv
// Shared types and helpers for the CRCU tap-clock switch sequencer:
// state encoding, ratio-select codes and the select-to-ratio table.
package crcu_tap_pkg;

  typedef enum logic [2:0] {
    OFF,
    LOAD,
    SETTLE,
    ALIGN,
    RUN,
    DRAIN
  } tap_state_t;

  localparam logic [2:0] SEL_10M  = 3'b000;
  localparam logic [2:0] SEL_25M  = 3'b001;
  localparam logic [2:0] SEL_40M  = 3'b010;
  localparam logic [2:0] SEL_80M  = 3'b011;
  localparam logic [2:0] SEL_100M = 3'b100;

  localparam logic [7:0] RATIO_RESET = 8'd120;

  // Divide ratios assume a 1.2 GHz divider source clock.
  function automatic logic [7:0] tap_ratio(input logic [2:0] sel);
    logic [7:0] ratio;
    case (sel)
      SEL_10M:  ratio = 8'd120;
      SEL_25M:  ratio = 8'd48;
      SEL_40M:  ratio = 8'd30;
      SEL_80M:  ratio = 8'd15;
      SEL_100M: ratio = 8'd12;
      default:  ratio = RATIO_RESET;
    endcase
    return ratio;
  endfunction

  function automatic logic tap_sel_legal(input logic [2:0] sel);
    return (sel <= SEL_100M);
  endfunction

endpackage

// File: rtl/tap_clk_switch_ctrl.sv
// Glitch-free tap-clock divider sequencer: programs, starts, gates and
// drains the tap clock divider from the tap clock control register fields.
module tap_clk_switch_ctrl
  import crcu_tap_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_TMO  = 255
) (
  input  logic       CRCU_CLK,
  input  logic       CRCU_RST_N,
  input  logic [2:0] sel,
  input  logic       clk_en,
  input  logic       clk_gate,
  input  logic       div_clk_lvl,
  output logic [7:0] div_ratio,
  output logic       div_load,
  output logic       div_run,
  output logic       tap_gate_en,
  output logic       busy,
  output logic       sel_err
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_TMO - 1);

  tap_state_t state, next_state;
  logic [2:0] cur_sel, cur_sel_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] div_ratio_d;
  logic       div_load_d, div_run_d, tap_gate_en_d, busy_d;
  logic       want_on, sel_ok, sel_new;

  assign want_on = clk_en & ~clk_gate;
  assign sel_ok  = tap_sel_legal(sel);
  assign sel_new = sel_ok && (sel != cur_sel);

  always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
    if (!CRCU_RST_N) begin
      state   <= OFF;
      cur_sel <= SEL_10M;
      cnt     <= '0;
    end else begin
      state   <= next_state;
      cur_sel <= cur_sel_d;
      cnt     <= cnt_d;
    end
  end

  // One shared counter: settle count in SETTLE, drain timeout in DRAIN.
  always_comb begin
    next_state = state;
    cur_sel_d  = cur_sel;
    cnt_d      = cnt;
    case (state)
      OFF: begin
        if (want_on && sel_ok) begin
          cur_sel_d  = sel;
          next_state = LOAD;
        end
      end
      LOAD: begin
        cnt_d      = '0;
        next_state = SETTLE;
      end
      SETTLE: begin
        if (!want_on) begin
          next_state = OFF;
        end else if (sel_new) begin
          cur_sel_d  = sel;
          next_state = LOAD;
        end else if (cnt == SETTLE_LAST) begin
          next_state = ALIGN;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      ALIGN: begin
        if (!want_on) begin
          next_state = OFF;
        end else if (sel_new) begin
          cur_sel_d  = sel;
          next_state = LOAD;
        end else if (!div_clk_lvl) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!want_on || sel_new) begin
          cnt_d      = '0;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        // A reverted request still drains and reloads; the divider state is unknown.
        if (!div_clk_lvl || (cnt == DRAIN_LAST)) begin
          if (want_on && sel_ok) begin
            cur_sel_d  = sel;
            next_state = LOAD;
          end else begin
            next_state = OFF;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: next_state = OFF;
    endcase
  end

  always_comb begin
    div_ratio_d   = div_ratio;
    div_load_d    = 1'b0;
    div_run_d     = 1'b0;
    tap_gate_en_d = 1'b0;
    busy_d        = 1'b0;
    case (next_state)
      LOAD: begin
        div_ratio_d = tap_ratio(cur_sel_d);
        div_load_d  = 1'b1;
        busy_d      = 1'b1;
      end
      SETTLE, ALIGN: begin
        div_run_d = 1'b1;
        busy_d    = 1'b1;
      end
      RUN: begin
        div_run_d     = 1'b1;
        tap_gate_en_d = 1'b1;
      end
      DRAIN: begin
        div_run_d     = 1'b1;
        tap_gate_en_d = 1'b1;
        busy_d        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
    if (!CRCU_RST_N) begin
      div_ratio   <= RATIO_RESET;
      div_load    <= 1'b0;
      div_run     <= 1'b0;
      tap_gate_en <= 1'b0;
      busy        <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      div_ratio   <= div_ratio_d;
      div_load    <= div_load_d;
      div_run     <= div_run_d;
      tap_gate_en <= tap_gate_en_d;
      busy        <= busy_d;
      sel_err     <= ~sel_ok;
    end
  end

endmodule

// File: tb/tb_tap_clk_switch_ctrl.sv
// Directed self-checking bench for tap_clk_switch_ctrl: start, switch,
// drain timeout, illegal select, settle restart/abort and async reset.
module tb_tap_clk_switch_ctrl;

  logic       CRCU_CLK;
  logic       CRCU_RST_N;
  logic [2:0] sel;
  logic       clk_en;
  logic       clk_gate;
  logic       div_clk_lvl;
  logic [7:0] div_ratio;
  logic       div_load;
  logic       div_run;
  logic       tap_gate_en;
  logic       busy;
  logic       sel_err;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  tap_clk_switch_ctrl #(
    .SETTLE_CYC(4),
    .DRAIN_TMO (255)
  ) dut (
    .CRCU_CLK   (CRCU_CLK),
    .CRCU_RST_N (CRCU_RST_N),
    .sel        (sel),
    .clk_en     (clk_en),
    .clk_gate   (clk_gate),
    .div_clk_lvl(div_clk_lvl),
    .div_ratio  (div_ratio),
    .div_load   (div_load),
    .div_run    (div_run),
    .tap_gate_en(tap_gate_en),
    .busy       (busy),
    .sel_err    (sel_err)
  );

  initial CRCU_CLK = 1'b0;
  always #5 CRCU_CLK = ~CRCU_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input int ratio, input logic load,
                            input logic run, input logic gate, input logic bsy);
    checkOutput({tag, ".ratio"}, 32'(div_ratio), 32'(ratio));
    checkOutput({tag, ".load"}, 32'(div_load), 32'(load));
    checkOutput({tag, ".run"}, 32'(div_run), 32'(run));
    checkOutput({tag, ".gate"}, 32'(tap_gate_en), 32'(gate));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic applyStimulus(input logic [2:0] s, input logic en,
                               input logic gt, input logic lvl);
    sel         = s;
    clk_en      = en;
    clk_gate    = gt;
    div_clk_lvl = lvl;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CRCU_CLK);
      @(negedge CRCU_CLK);
    end
  endtask

  // After the LOAD check: four settle cycles, one align cycle, then RUN.
  task automatic settleToRun(input string tag, input int ratio);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkState({tag, ".settle"}, ratio, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    tick(1);
    checkState({tag, ".align"}, ratio, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkState({tag, ".run"}, ratio, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    CRCU_RST_N = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge CRCU_CLK);
    checkState("reset", 120, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.sel_err", 32'(sel_err), 32'd0);
    CRCU_RST_N = 1'b1;
    tick(2);
    checkState("idle_off", 120, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] start at ratio 120");
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkState("start.load", 120, 1'b1, 1'b0, 1'b0, 1'b1);
    settleToRun("start", 120);

    $display("[TB] switch to ratio 48");
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkState("sw48.drain", 120, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkState("sw48.load", 48, 1'b1, 1'b0, 1'b0, 1'b1);
    settleToRun("sw48", 48);

    $display("[TB] switch to ratio 15 with divider held high");
    applyStimulus(3'b011, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkState("sw15.drain_hold", 48, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    div_clk_lvl = 1'b0;
    tick(1);
    checkState("sw15.load", 15, 1'b1, 1'b0, 1'b0, 1'b1);
    settleToRun("sw15", 15);

    $display("[TB] gate request with divider stuck high");
    applyStimulus(3'b011, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkState("tmo.drain_first", 15, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(254);
    checkState("tmo.drain_last", 15, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkState("tmo.off", 15, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] illegal select");
    applyStimulus(3'b110, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("illegal.sel_err", 32'(sel_err), 32'd1);
    checkState("illegal.off", 15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkState("illegal.hold", 15, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("legal.sel_err", 32'(sel_err), 32'd0);
    checkState("legal.load", 12, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] reselect during settle");
    tick(2);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkState("resel30.load", 30, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(3);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkState("resel48.load", 48, 1'b1, 1'b0, 1'b0, 1'b1);
    settleToRun("resel48", 48);

    $display("[TB] abort during settle");
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    tick(2);
    checkState("abort.load", 120, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkState("abort.settle", 120, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkState("abort.off", 120, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6);
    checkState("abort.stay_off", 120, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] async reset during drain");
    applyStimulus(3'b011, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkState("rst.load", 15, 1'b1, 1'b0, 1'b0, 1'b1);
    settleToRun("rst", 15);
    applyStimulus(3'b100, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkState("rst.drain", 15, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    CRCU_RST_N = 1'b0;
    #1;
    checkState("rst.async", 120, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CRCU_CLK);
    div_clk_lvl = 1'b0;
    CRCU_RST_N  = 1'b1;
    tick(1);
    checkState("rst.reload", 12, 1'b1, 1'b0, 1'b0, 1'b1);
    settleToRun("rst.restart", 12);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/tap_clk_switch_ctrl.md
Name: tap_clk_switch_ctrl

Overview:
Sequencer for the CRCU tap-clock divider. It turns the tap clock control register fields (ratio select, enable, gate) into a glitch-free divider program/start/gate sequence. The tap clock can then be retargeted or stopped at runtime without runt pulses. It sits between the APB register bank and the tap clock divider/gate cell, all in the CRCU_CLK domain.

Parameters:
SETTLE_CYC, 4, CRCU_CLK cycles the divider runs after load before the gate may open (1..15)
DRAIN_TMO, 255, max CRCU_CLK cycles to wait for a low divider phase before forcing the gate closed (1..255)

Ports:
CRCU_CLK  in  1  CRCU reference clock (120 MHz nominal); only clock
CRCU_RST_N  in  1  asynchronous active-low reset
sel  in  3  tap_clock_ctl_reg[2:0] ratio select
clk_en  in  1  tap_clock_ctl_reg[3] clock enable
clk_gate  in  1  tap_clock_ctl_reg[4] clock gating request (1 = stop)
div_clk_lvl  in  1  current divider output level, sampled in CRCU_CLK domain
div_ratio  out  8  divide ratio to divider
div_load  out  1  one-cycle strobe: divider reloads div_ratio and resets its count
div_run  out  1  divider count enable
tap_gate_en  out  1  tap clock gate enable (1 = tap_clk passes)
busy  out  1  high while a start/switch/stop sequence is in progress
sel_err  out  1  high while sel holds an illegal code

Behaviour:
- Interface: one clock CRCU_CLK; CRCU_RST_N is asynchronous, active-low.
- Reset values: state OFF, div_ratio=120, div_load=0, div_run=0, tap_gate_en=0, busy=0, sel_err=0, cur_sel=000, counters 0.
- Ratio table: 000→120 (10 MHz), 001→48 (25 MHz), 010→30 (40 MHz), 011→15 (80 MHz), 100→12 (100 MHz). Codes 101–111 are illegal.
- sel_err is registered: 1 the cycle after sel goes illegal, 0 the cycle after it goes legal. An illegal sel is ignored; cur_sel is kept and no switch occurs.
- want_on = clk_en & ~clk_gate. All inputs are sampled on the CRCU_CLK rising edge. Outputs are registered.
- busy = 1 in LOAD, SETTLE, ALIGN and DRAIN; 0 in OFF and RUN.
- States:
  - OFF: div_run=0, gate=0. If want_on and sel legal: cur_sel<=sel, go to LOAD.
  - LOAD (1 cycle): div_ratio<=table(cur_sel), div_load=1, div_run=0. Go to SETTLE.
  - SETTLE: div_run=1, settle counter runs 0..SETTLE_CYC-1.
    - If ~want_on: go to OFF (div_run=0 next cycle).
    - If sel is legal and differs from cur_sel: cur_sel<=sel, go to LOAD (restart).
    - When the count completes: go to ALIGN.
  - ALIGN: wait for div_clk_lvl==0. The abort/reselect checks are the same as SETTLE. On low: tap_gate_en<=1, go to RUN.
  - RUN: gate=1, div_run=1. If ~want_on, or sel is legal and differs from cur_sel: go to DRAIN and clear the drain counter.
  - DRAIN: div_run=1. Wait for div_clk_lvl==0, or drain counter == DRAIN_TMO-1. On either: tap_gate_en<=0, then:
    - if want_on and sel legal: cur_sel<=sel, go to LOAD;
    - else go to OFF.
    - If the request reverts during DRAIN (want_on and sel==cur_sel), still complete the drain and reload.
- The gate only opens or closes on a cycle where div_clk_lvl was sampled low (timeout excepted). This guarantees no truncated high pulse.
- Start latency, OFF to gate open: 1 (OFF) + 1 (LOAD) + SETTLE_CYC + ALIGN wait (≥1) cycles.
- div_ratio changes only in LOAD, so it is stable whenever tap_gate_en=1.
- Reset asserted mid-sequence: all outputs go to reset values immediately (asynchronous).

Decomposition:
- Package crcu_tap_pkg holds:
  - the state enum (OFF, LOAD, SETTLE, ALIGN, RUN, DRAIN);
  - sel code localparams;
  - a function tap_ratio(sel) returning 8-bit ratio;
  - a function tap_sel_legal(sel).
- Single module; no sub-module is needed. The settle and drain counters share one 8-bit counter.

Test Plan:
- Reset then sel=000, clk_en=1, clk_gate=0 → next cycle LOAD with div_load=1 and div_ratio=120. div_run=1 for 4 cycles, then gate opens on the first div_clk_lvl low; busy drops with it.
- In RUN at ratio 48, write sel=011 with div_clk_lvl high for 10 cycles → tap_gate_en stays 1 until div_clk_lvl goes low, then 0. LOAD follows with div_ratio=15, then the gate reopens after settle+align.
- In RUN, set clk_gate=1 with div_clk_lvl stuck at 1 → tap_gate_en forced to 0 after exactly 255 DRAIN cycles. State goes OFF, div_run=0, busy=0.
- sel=110 with clk_en=1 from OFF → sel_err=1, state stays OFF, no div_load. Then sel=100 → sel_err clears and LOAD follows with div_ratio=12.
- During SETTLE (ratio 30), change sel to 001 → returns to LOAD with div_ratio=48, and the settle count restarts from 0. Dropping clk_en in SETTLE → OFF, gate never opened.
- Assert CRCU_RST_N=0 mid-DRAIN, off a clock edge → all outputs go to reset values immediately. After release with want_on still high, a full LOAD→RUN sequence completes.
